// File: rtl/crypto_pkg.sv
// Shared definitions for the crypto byte-stream framing controller.
// Header layout: [7:4] magic, [3:1] reserved (must be zero), [0] sel.
package crypto_pkg;

  typedef enum logic [2:0] {
    ST_HDR   = 3'd0,
    ST_KEY   = 3'd1,
    ST_LEN   = 3'd2,
    ST_DATA  = 3'd3,
    ST_DRAIN = 3'd4
  } frame_state_t;

  localparam int HDR_MAGIC_HI = 7;
  localparam int HDR_MAGIC_LO = 4;
  localparam logic [7:0] HDR_RSVD = 8'h0E;
  localparam int HDR_SEL_BIT  = 0;

endpackage

// File: rtl/crypto_frame_ctrl.sv
// Frame parser feeding an external combinational crypto core; results are
// registered once and presented on a valid/ready byte sink.
//
// state    | meaning
// ST_HDR   | wait for header byte; bad headers dropped with hdr_err pulse
// ST_KEY   | capture key byte
// ST_LEN   | capture payload length; zero length completes the frame
// ST_DATA  | pass payload bytes through the core, one per accept
// ST_DRAIN | last result pending; wait for sink handshake
module crypto_frame_ctrl
  import crypto_pkg::*;
#(
  parameter logic [3:0] MAGIC = 4'hA
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       abort,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       core_sel,
  output logic [7:0] core_inp,
  output logic [7:0] core_key,
  input  logic [7:0] core_out,
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       busy,
  output logic       frame_done,
  output logic       hdr_err
);

  frame_state_t state, state_nxt;
  logic         sel_r;
  logic [7:0]   key_r;
  logic [7:0]   cnt;
  logic         take;
  logic         out_hs;
  logic         hdr_ok;

  always_comb begin
    in_ready = 1'b0;
    case (state)
      ST_HDR, ST_KEY, ST_LEN: in_ready = 1'b1;
      ST_DATA:                in_ready = !out_valid || out_ready;
      default:                in_ready = 1'b0;
    endcase
  end

  // abort wins over any handshake in the same cycle
  assign take     = in_valid && in_ready && !abort;
  assign out_hs   = out_valid && out_ready && !abort;
  assign hdr_ok   = (in_data[HDR_MAGIC_HI:HDR_MAGIC_LO] == MAGIC) &&
                    ((in_data & HDR_RSVD) == 8'h00);
  assign core_sel = sel_r;
  assign core_key = key_r;
  assign core_inp = (state == ST_DATA) ? in_data : 8'h00;
  assign busy     = (state != ST_HDR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_HDR;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_HDR:   if (take && hdr_ok) state_nxt = ST_KEY;
      ST_KEY:   if (take) state_nxt = ST_LEN;
      ST_LEN:   if (take) state_nxt = (in_data == 8'h00) ? ST_HDR : ST_DATA;
      ST_DATA:  if (take && cnt == 8'd1) state_nxt = ST_DRAIN;
      ST_DRAIN: if (out_hs) state_nxt = ST_HDR;
      default:  state_nxt = ST_HDR;
    endcase
    if (abort) state_nxt = ST_HDR;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sel_r      <= 1'b0;
      key_r      <= 8'h00;
      cnt        <= 8'h00;
      out_data   <= 8'h00;
      out_valid  <= 1'b0;
      frame_done <= 1'b0;
      hdr_err    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      hdr_err    <= 1'b0;
      if (abort) begin
        out_valid <= 1'b0;
        cnt       <= 8'h00;
      end else begin
        case (state)
          ST_HDR: if (take) begin
            if (hdr_ok) sel_r   <= in_data[HDR_SEL_BIT];
            else        hdr_err <= 1'b1;
          end
          ST_KEY: if (take) key_r <= in_data;
          ST_LEN: if (take) begin
            cnt <= in_data;
            if (in_data == 8'h00) frame_done <= 1'b1;
          end
          // a new accept while the sink takes the old byte keeps out_valid high
          ST_DATA: begin
            if (take) begin
              out_data  <= core_out;
              out_valid <= 1'b1;
              cnt       <= cnt - 8'd1;
            end else if (out_hs) begin
              out_valid <= 1'b0;
            end
          end
          ST_DRAIN: if (out_hs) begin
            out_valid  <= 1'b0;
            frame_done <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_crypto_frame_ctrl.sv
// Scoreboard bench for crypto_frame_ctrl with a reversible stand-in core:
// encrypt = rotl1(inp ^ key), decrypt = rotr1(inp) ^ key.
module tb_crypto_frame_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       abort = 1'b0;
  logic [7:0] in_data = 8'h00;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       core_sel;
  logic [7:0] core_inp;
  logic [7:0] core_key;
  logic [7:0] core_out;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic       busy;
  logic       frame_done;
  logic       hdr_err;

  logic [7:0] enc_x, dec_x;
  assign enc_x    = core_inp ^ core_key;
  assign dec_x    = {core_inp[0], core_inp[7:1]};
  assign core_out = core_sel ? {enc_x[6:0], enc_x[7]} : (dec_x ^ core_key);

  crypto_frame_ctrl #(.MAGIC(4'hA)) dut (
    .clk(clk), .rst(rst), .abort(abort),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .core_sel(core_sel), .core_inp(core_inp), .core_key(core_key),
    .core_out(core_out),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .frame_done(frame_done), .hdr_err(hdr_err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_done  = 0;
  int n_herr  = 0;
  int n_out   = 0;
  bit lat_check = 1'b1;
  logic [7:0] exp_q[$];
  int         cyc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // monitor: pops the scoreboard on every output handshake
  always @(negedge clk) begin
    if (!rst) begin
      if (frame_done) n_done++;
      if (hdr_err) n_herr++;
      if (out_valid && out_ready && !abort) begin
        n_out++;
        if (exp_q.size() == 0) begin
          chk("unexpected_output", {24'h0, out_data}, 32'hFFFF_FFFF);
        end else begin
          logic [7:0] e;
          int c;
          e = exp_q.pop_front();
          c = cyc_q.pop_front();
          chk("out_data", {24'h0, out_data}, {24'h0, e});
          if (lat_check) chk("latency", cyc, c);
        end
      end
    end
  end

  task automatic send(input logic [7:0] b, input bit push, input logic [7:0] e);
    bit ok = 1'b0;
    in_data  = b;
    in_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        if (push) begin
          exp_q.push_back(e);
          cyc_q.push_back(cyc + 1);
        end
        @(posedge clk);
        #2;
      end
    end
    if (!ok) chk("in_ready_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  int done0, out0, herr0;

  initial begin
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready",   in_ready,   1);
    chk("rst_out_valid",  out_valid,  0);
    chk("rst_out_data",   out_data,   0);
    chk("rst_core_sel",   core_sel,   0);
    chk("rst_core_key",   core_key,   0);
    chk("rst_core_inp",   core_inp,   0);
    chk("rst_busy",       busy,       0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_hdr_err",    hdr_err,    0);
    @(posedge clk); #2;

    // encrypt frame: A5,7E under key 3C -> 33,84
    done0 = n_done;
    send(8'hA1, 0, 0); send(8'h3C, 0, 0); send(8'h02, 0, 0);
    send(8'hA5, 1, 8'h33); send(8'h7E, 1, 8'h84);
    idle(4);
    chk("enc_frame_done", n_done - done0, 1);
    chk("enc_queue_empty", exp_q.size(), 0);
    chk("enc_core_sel", core_sel, 1);
    chk("enc_core_key", core_key, 8'h3C);
    chk("enc_busy_idle", busy, 0);
    chk("hdr_core_inp", core_inp, 0);

    // round trip: decrypt back to plaintext
    done0 = n_done;
    send(8'hA0, 0, 0); send(8'h3C, 0, 0); send(8'h02, 0, 0);
    send(8'h33, 1, 8'hA5); send(8'h84, 1, 8'h7E);
    idle(4);
    chk("dec_frame_done", n_done - done0, 1);
    chk("dec_queue_empty", exp_q.size(), 0);
    chk("dec_core_sel", core_sel, 0);

    // backpressure: sink stalls 5 cycles after first output
    done0 = n_done; out0 = n_out; lat_check = 1'b0;
    send(8'hA1, 0, 0); send(8'h3C, 0, 0); send(8'h02, 0, 0);
    send(8'hA5, 1, 8'h33);
    out_ready = 1'b0;
    in_data = 8'h7E; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_data", out_data, 8'h33);
      chk("bp_in_ready", in_ready, 0);
      @(posedge clk); #2;
    end
    out_ready = 1'b1;
    send(8'h7E, 1, 8'h84);
    idle(4);
    chk("bp_outputs", n_out - out0, 2);
    chk("bp_queue_empty", exp_q.size(), 0);
    chk("bp_frame_done", n_done - done0, 1);
    lat_check = 1'b1;

    // bad header, then an empty frame
    done0 = n_done; out0 = n_out; herr0 = n_herr;
    send(8'h5F, 0, 0);
    @(negedge clk);
    chk("badhdr_busy", busy, 0);
    @(posedge clk); #2;
    chk("badhdr_pulses", n_herr - herr0, 1);
    send(8'hA1, 0, 0); send(8'h3C, 0, 0); send(8'h00, 0, 0);
    @(negedge clk);
    chk("len0_frame_done_now", frame_done, 1);
    idle(3);
    chk("len0_frame_done", n_done - done0, 1);
    chk("len0_outputs", n_out - out0, 0);
    chk("len0_hdr_err", n_herr - herr0, 1);

    // abort while a result is pending
    done0 = n_done;
    send(8'hA1, 0, 0); send(8'h3C, 0, 0); send(8'h04, 0, 0);
    send(8'hA5, 1, 8'h33);
    send(8'h7E, 0, 0);
    out_ready = 1'b0;
    abort = 1'b1;
    @(negedge clk);
    chk("pre_abort_valid", out_valid, 1);
    @(posedge clk); #2;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_in_ready", in_ready, 1);
    @(posedge clk); #2;
    out_ready = 1'b1;
    idle(3);
    chk("abort_no_done", n_done - done0, 0);
    send(8'hA1, 0, 0); send(8'h3C, 0, 0); send(8'h01, 0, 0);
    send(8'hA5, 1, 8'h33);
    idle(4);
    chk("post_abort_done", n_done - done0, 1);
    chk("post_abort_queue", exp_q.size(), 0);

    // asynchronous reset in DATA
    send(8'hA1, 0, 0); send(8'h3C, 0, 0); send(8'h03, 0, 0);
    out_ready = 1'b0;
    send(8'hA5, 0, 0);
    @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    chk("pre_rst_valid", out_valid, 1);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_busy", busy, 0);
    chk("arst_in_ready", in_ready, 1);
    chk("arst_core_sel", core_sel, 0);
    chk("arst_core_key", core_key, 0);
    chk("arst_core_inp", core_inp, 0);
    chk("arst_frame_done", frame_done, 0);
    @(posedge clk); #2;
    rst = 1'b0;
    out_ready = 1'b1;
    idle(2);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
